// File: rtl/cod_alu_pkg.sv
// Shared types for the ALU execute stage: widths, ALU opcodes, result entry layout.
package cod_alu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int REG_AW     = 5;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [REG_AW-1:0]     rd;
    logic                  wen;
    logic                  zero;
    logic                  carry;
    logic                  overflow;
    logic                  illegal;
  } res_entry_t;

  function automatic logic aluop_legal(input logic [2:0] op);
    return (op == ALUOP_AND) || (op == ALUOP_OR) || (op == ALUOP_ADD) ||
           (op == ALUOP_SUB) || (op == ALUOP_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/OR/ADD/SUB/SLT. Carry/overflow always come from the adder,
// so they are meaningless for logic ops; SUB carry is reported as a borrow.
module alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            aluop_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  carry_o,
  output logic                  overflow_o
);

  logic [DATA_WIDTH-1:0] b_m;
  logic [DATA_WIDTH:0]   sum;
  logic                  lt;

  assign b_m = aluop_i[2] ? ~b_i : b_i;
  assign sum = {1'b0, a_i} + {1'b0, b_m} + {{DATA_WIDTH{1'b0}}, aluop_i[2]};

  assign carry_o    = aluop_i[2] ? ~sum[DATA_WIDTH] : sum[DATA_WIDTH];
  assign overflow_o = (a_i[DATA_WIDTH-1] == b_m[DATA_WIDTH-1]) &&
                      (sum[DATA_WIDTH-1] != a_i[DATA_WIDTH-1]);
  assign lt         = sum[DATA_WIDTH-1] ^ overflow_o;

  always_comb begin
    result_o = '0;
    case (aluop_i[1:0])
      2'b00:   result_o = a_i & b_i;
      2'b01:   result_o = a_i | b_i;
      2'b10:   result_o = sum[DATA_WIDTH-1:0];
      default: result_o = {{(DATA_WIDTH-1){1'b0}}, lt};
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/ex_skid_buf.sv
// Two-entry in-order result buffer; a push lands at the head next cycle when empty.
// in_ready_o is registered and drops the cycle after the second entry is captured.
module ex_skid_buf
  import cod_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  res_entry_t push_dat_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output res_entry_t head_o
);

  buf_state_e state_q, state_d;
  res_entry_t head_q, head_d;
  res_entry_t tail_q, tail_d;
  logic       in_ready_q;
  logic       pop;

  assign out_valid_o = (state_q != BUF_EMPTY);
  assign pop         = out_valid_o && out_ready_i;
  assign head_o      = head_q;
  assign in_ready_o  = in_ready_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      BUF_EMPTY: begin
        if (push_i) begin
          head_d  = push_dat_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        // Push and pop together: the old head leaves, the new entry takes its place.
        if (push_i && pop) begin
          head_d = push_dat_i;
        end else if (push_i) begin
          tail_d  = push_dat_i;
          state_d = BUF_TWO;
        end else if (pop) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        if (pop) begin
          head_d  = tail_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUF_EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= (state_d != BUF_TWO);
    end
  end

endmodule

// File: rtl/alu_ex_stage.sv
// Execute stage: operand forwarding from the last accepted op, ALU, flag cleanup, 2-entry output buffer.
// Result reaches the buffer head one cycle after accept; stalls upstream via registered in_ready.
module alu_ex_stage #(
  parameter int DATA_WIDTH = cod_alu_pkg::DATA_WIDTH,
  parameter int REG_AW     = cod_alu_pkg::REG_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_aluop,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic                  in_wen,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [REG_AW-1:0]     out_rd,
  output logic                  out_wen,
  output logic                  out_zero,
  output logic                  out_carry,
  output logic                  out_overflow,
  output logic                  out_illegal
);

  import cod_alu_pkg::*;

  logic                  fwd_v_q, fwd_v_d;
  logic [REG_AW-1:0]     fwd_rd_q, fwd_rd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

  logic [DATA_WIDTH-1:0] a_eff, b_eff, alu_result;
  logic                  alu_zero, alu_carry, alu_overflow;
  logic                  accept, legal, arith;
  res_entry_t            push_dat, head;

  assign accept = in_valid && in_ready;
  assign a_eff  = (fwd_v_q && (in_rs1 == fwd_rd_q)) ? fwd_data_q : in_a;
  assign b_eff  = (fwd_v_q && (in_rs2 == fwd_rd_q)) ? fwd_data_q : in_b;

  alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i        (a_eff),
    .b_i        (b_eff),
    .aluop_i    (in_aluop),
    .result_o   (alu_result),
    .zero_o     (alu_zero),
    .carry_o    (alu_carry),
    .overflow_o (alu_overflow)
  );

  assign legal = aluop_legal(in_aluop);
  assign arith = (in_aluop == ALUOP_ADD) || (in_aluop == ALUOP_SUB);

  // Adder flags only mean something for ADD/SUB; illegal ops produce a clean zero entry.
  always_comb begin
    push_dat         = '0;
    push_dat.rd      = in_rd;
    push_dat.illegal = !legal;
    push_dat.wen     = in_wen && legal && (in_rd != '0);
    if (legal) begin
      push_dat.result   = alu_result;
      push_dat.zero     = alu_zero;
      push_dat.carry    = arith && alu_carry;
      push_dat.overflow = arith && alu_overflow;
    end else begin
      push_dat.zero = 1'b1;
    end
  end

  always_comb begin
    fwd_v_d    = fwd_v_q;
    fwd_rd_d   = fwd_rd_q;
    fwd_data_d = fwd_data_q;
    if (accept) begin
      fwd_v_d    = push_dat.wen;
      fwd_rd_d   = in_rd;
      fwd_data_d = push_dat.result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_v_q    <= 1'b0;
      fwd_rd_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_v_q    <= fwd_v_d;
      fwd_rd_q   <= fwd_rd_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  ex_skid_buf u_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (accept),
    .push_dat_i  (push_dat),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .head_o      (head)
  );

  assign out_result   = head.result;
  assign out_rd       = head.rd;
  assign out_wen      = head.wen;
  assign out_zero     = head.zero;
  assign out_carry    = head.carry;
  assign out_overflow = head.overflow;
  assign out_illegal  = head.illegal;

endmodule

// File: doc/alu_ex_stage.md
Name: alu_ex_stage

Overview:
- Execute stage that sits between operand read (register file) and write-back.
- Accepts one operation per cycle over a valid/ready handshake and forwards the most recent result into A/B on register match.
- Drives the existing combinational alu instance, sanitises its flags, and registers result and flags into a 2-entry output skid buffer for the write-back consumer.

Parameters:
- DATA_WIDTH, 32, operand/result width; must match alu.
- REG_AW, 5, register address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers an operation.
- in_ready  output  1  stage can accept; registered, depends only on buffer occupancy.
- in_aluop  input  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal.
- in_a  input  DATA_WIDTH  operand A from register read.
- in_b  input  DATA_WIDTH  operand B from register read.
- in_rs1  input  REG_AW  source register of A.
- in_rs2  input  REG_AW  source register of B.
- in_rd  input  REG_AW  destination register.
- in_wen  input  1  operation writes in_rd.
- out_valid  output  1  head of buffer valid.
- out_ready  input  1  downstream accepts head.
- out_result  output  DATA_WIDTH  registered result.
- out_rd  output  REG_AW  destination.
- out_wen  output  1  write enable; forced 0 for illegal op or rd==0.
- out_zero  output  1  result == 0.
- out_carry  output  1  ALU CarryOut for ADD/SUB, else 0.
- out_overflow  output  1  ALU Overflow for ADD/SUB, else 0.
- out_illegal  output  1  aluop not in legal set.

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: buffer EMPTY, in_ready=1, out_valid=0, all out_* data =0, forwarding register invalid.
- Handshake: accept when in_valid&&in_ready; pop when out_valid&&out_ready. Inputs need not be held after acceptance.
- Forwarding register (fwd_v, fwd_rd, fwd_data): loaded on every accept with (in_wen && in_rd!=0 && legal, in_rd, result).
  - Holds the last accepted op independent of whether it has left the buffer.
  - A_eff = fwd_data if fwd_v && in_rs1==fwd_rd, else in_a; B_eff likewise with in_rs2.
- ALU: combinational on A_eff/B_eff/in_aluop in the accept cycle.
  - Illegal op: result 0, zero=1, carry=0, overflow=0, illegal=1, wen=0.
  - AND/OR/SLT: carry and overflow forced 0, never X.
  - SLT result is 0 or 1 (signed compare).
  - ADD/SUB wrap modulo 2^DATA_WIDTH.
- Latency: op accepted at edge N appears at the buffer head at N+1 if buffer was EMPTY; otherwise behind older entry, order preserved.
- Buffer FSM EMPTY/ONE/TWO:
  - EMPTY: push -> ONE.
  - ONE: push only -> TWO; pop only -> EMPTY; push+pop -> ONE, new entry becomes head.
  - TWO: pop -> ONE (no push possible).
- in_ready = (state != TWO), registered, so it deasserts the cycle after the buffer fills.
- out_* hold stable while out_valid && !out_ready.
- Reset asserted mid-stream: buffer and forwarding contents discarded at that edge; no partial outputs.

Decomposition:
- Shared package cod_alu_pkg: DATA_WIDTH, REG_AW, ALUop localparams (AND/OR/ADD/SUB/SLT), legal-op check function, result-entry struct (result, rd, wen, zero, carry, overflow, illegal).
- Sub-module ex_skid_buf: 2-entry FIFO of result entries with the EMPTY/ONE/TWO FSM and registered in_ready.
- Top instantiates alu unchanged plus forwarding mux and flag sanitiser.

Test Plan:
- Reset then ADD a=0x7FFFFFFF b=1 rd=3, out_ready=1 -> next cycle out_result=0x80000000, overflow=1, carry=0, zero=0, wen=1.
- SUB a=0 b=1 rd=4 -> result 0xFFFFFFFF, carry=1, overflow=0. SLT a=0xFFFFFFFF b=1 -> result 1, carry=0, overflow=0.
- Back-to-back forwarding: ADD rd=5 a=2 b=3, then OR rs1=5 in_a=0xDEAD b=0x8 rd=6 -> second result 0xD. Repeat with rd=0 -> no forward, result 0xDEAD|0x8=0xDEAD.
- Backpressure: out_ready=0, push 3 ops -> in_ready drops after 2 accepted, third held. Release -> results in order, head stable while stalled.
- Simultaneous push+pop in ONE -> state stays ONE, no loss or duplication across 10 streamed ops.
- aluop=011 -> illegal=1, result 0, wen=0, no X on any output. rst mid-stream with 2 entries -> out_valid=0 and in_ready=1 next cycle, forwarding cleared.
